binary_onehot_encoder: RTL and testbench



---
 rtl/binary_onehot_pkg.sv | 22 ++
 rtl/onehot_to_binary.sv | 24 ++
 rtl/binary_onehot_encoder.sv | 91 +++++++++
 tb/tb_binary_onehot_encoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/binary_onehot_pkg.sv
// rtl/binary_onehot_pkg.sv - shared constants and one-hot helper functions
package binary_onehot_pkg;

  localparam int DEFAULT_WIDTH = 4;
  // Widest one-hot vector the helpers handle; callers cast to their own width.
  localparam int MAX_OUT_W     = 256;

  function automatic logic [MAX_OUT_W-1:0] onehot_f(input logic [31:0] bin,
                                                    input int unsigned out_width);
    logic [MAX_OUT_W-1:0] result;
    result = '0;
    if (bin < out_width) begin
      result[bin[7:0]] = 1'b1;
    end
    return result;
  endfunction

  function automatic logic is_onehot_f(input logic [MAX_OUT_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_binary.sv
// rtl/onehot_to_binary.sv - priority-free OR-tree one-hot to binary encoder
module onehot_to_binary #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 4
)(
  input  logic [IN_W-1:0]  vec_i,
  output logic [OUT_W-1:0] idx_o,
  output logic             valid_o
);

  // Each index bit ORs every input position whose index has that bit set.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      for (int b = 0; b < OUT_W; b++) begin
        if (((i >> b) & 1) == 1) begin
          idx_o[b] = idx_o[b] | vec_i[i];
        end
      end
    end
    valid_o = |vec_i;
  end

endmodule

// File: rtl/binary_onehot_encoder.sv
// rtl/binary_onehot_encoder.sv - registered binary to one-hot encoder
// Optional self-checker enabled by BINARY_ONEHOT_ENCODER_CHECK_EN.
module binary_onehot_encoder
  import binary_onehot_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int OUT_WIDTH = 2**WIDTH
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_bin,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_onehot,
  output logic                 out_range,
  output logic                 chk_err
);

  logic                 out_valid_q,  out_valid_d;
  logic [OUT_WIDTH-1:0] out_onehot_q, out_onehot_d;
  logic                 out_range_q,  out_range_d;

  always_comb begin
    out_valid_d  = 1'b0;
    out_onehot_d = out_onehot_q;
    out_range_d  = out_range_q;
    if (in_valid) begin
      out_valid_d  = 1'b1;
      out_onehot_d = OUT_WIDTH'(onehot_f(32'(in_bin), OUT_WIDTH));
      out_range_d  = 32'(in_bin) >= 32'(OUT_WIDTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_range_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_range_q  <= out_range_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_range  = out_range_q;

`ifdef BINARY_ONEHOT_ENCODER_CHECK_EN
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] dec_idx;
  logic             dec_valid;
  logic             chk_err_q, chk_err_d;

  onehot_to_binary #(
    .IN_W  (OUT_WIDTH),
    .OUT_W (WIDTH)
  ) u_dec (
    .vec_i   (out_onehot_q),
    .idx_o   (dec_idx),
    .valid_o (dec_valid)
  );

  // bin_q tracks the index behind the result currently held on the outputs.
  always_comb begin
    bin_d     = in_valid ? in_bin : bin_q;
    chk_err_d = chk_err_q;
    if (out_valid_q && !out_range_q) begin
      if (!is_onehot_f(MAX_OUT_W'(out_onehot_q)) || !dec_valid || (dec_idx != bin_q)) begin
        chk_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_onehot_encoder.sv
// tb/tb_binary_onehot_encoder.sv - directed self-checking bench for binary_onehot_encoder
module tb_binary_onehot_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_bin;

  logic        out_valid;
  logic [15:0] out_onehot;
  logic        out_range;
  logic        chk_err;

  logic        out_valid10;
  logic [9:0]  out_onehot10;
  logic        out_range10;
  logic        chk_err10;

  int n_cmp = 0;
  int n_mis = 0;

  binary_onehot_encoder #(.WIDTH(4), .OUT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bin     (in_bin),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_range  (out_range),
    .chk_err    (chk_err)
  );

  binary_onehot_encoder #(.WIDTH(4), .OUT_WIDTH(10)) dut10 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bin     (in_bin),
    .out_valid  (out_valid10),
    .out_onehot (out_onehot10),
    .out_range  (out_range10),
    .chk_err    (chk_err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_bin = 4'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", c, out_valid); end
      n_cmp++; if (out_onehot !== 16'h0000) begin n_mis++; $display("FAIL reset_onehot cyc=%0d got=%h exp=0000", c, out_onehot); end
      n_cmp++; if (out_range !== 1'b0) begin n_mis++; $display("FAIL reset_range cyc=%0d got=%b exp=0", c, out_range); end
      n_cmp++; if (chk_err !== 1'b0) begin n_mis++; $display("FAIL reset_chk cyc=%0d got=%b exp=0", c, chk_err); end
      n_cmp++; if (out_valid10 !== 1'b0 || out_range10 !== 1'b0) begin n_mis++; $display("FAIL reset_dut10 cyc=%0d got v=%b r=%b exp v=0 r=0", c, out_valid10, out_range10); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [15:0] exp;
    in_valid = 1'b1; in_bin = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp = 16'h0001 << i;
      n_cmp++; if (out_onehot !== exp) begin n_mis++; $display("FAIL sweep_onehot idx=%0d got=%h exp=%h", i, out_onehot, exp); end
      n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL sweep_valid idx=%0d got=%b exp=1", i, out_valid); end
      n_cmp++; if (out_range !== 1'b0) begin n_mis++; $display("FAIL sweep_range idx=%0d got=%b exp=0", i, out_range); end
      n_cmp++; if (chk_err !== 1'b0) begin n_mis++; $display("FAIL sweep_chk idx=%0d got=%b exp=0", i, chk_err); end
      if (i < 15) in_bin = 4'(i + 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    in_valid = 1'b1; in_bin = 4'd3;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0008) begin n_mis++; $display("FAIL hold_load got=%h exp=0008", out_onehot); end
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL hold_load_valid got=%b exp=1", out_valid); end
    in_valid = 1'b0; in_bin = 4'd9;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0008) begin n_mis++; $display("FAIL hold_keep got=%h exp=0008", out_onehot); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_onehot10 !== 10'h008) begin n_mis++; $display("FAIL hold_keep10 got=%h exp=008", out_onehot10); end
  endtask

  task automatic test_out_of_range();
    in_valid = 1'b1; in_bin = 4'd12;
    @(negedge clk);
    n_cmp++; if (out_onehot10 !== 10'h000) begin n_mis++; $display("FAIL oor_onehot got=%h exp=000", out_onehot10); end
    n_cmp++; if (out_range10 !== 1'b1) begin n_mis++; $display("FAIL oor_range got=%b exp=1", out_range10); end
    n_cmp++; if (out_valid10 !== 1'b1) begin n_mis++; $display("FAIL oor_valid got=%b exp=1", out_valid10); end
    n_cmp++; if (out_onehot !== 16'h1000 || out_range !== 1'b0) begin n_mis++; $display("FAIL oor_full got=%h r=%b exp=1000 r=0", out_onehot, out_range); end
    in_bin = 4'd9;
    @(negedge clk);
    n_cmp++; if (out_onehot10 !== 10'h200) begin n_mis++; $display("FAIL edge_onehot got=%h exp=200", out_onehot10); end
    n_cmp++; if (out_range10 !== 1'b0) begin n_mis++; $display("FAIL edge_range got=%b exp=0", out_range10); end
    n_cmp++; if (chk_err10 !== 1'b0) begin n_mis++; $display("FAIL edge_chk10 got=%b exp=0", chk_err10); end
    in_bin = 4'd15;
    @(negedge clk);
    n_cmp++; if (out_onehot10 !== 10'h000 || out_range10 !== 1'b1) begin n_mis++; $display("FAIL max_oor got=%h r=%b exp=000 r=1", out_onehot10, out_range10); end
    in_valid = 1'b0;
  endtask

  task automatic test_midstream_reset();
    in_valid = 1'b1; in_bin = 4'd1;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0002) begin n_mis++; $display("FAIL mid_first got=%h exp=0002", out_onehot); end
    in_bin = 4'd2;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0004) begin n_mis++; $display("FAIL mid_second got=%h exp=0004", out_onehot); end
    in_bin = 4'd3; rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0000 || out_valid !== 1'b0) begin n_mis++; $display("FAIL mid_reset got=%h v=%b exp=0000 v=0", out_onehot, out_valid); end
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0000 || out_valid !== 1'b0) begin n_mis++; $display("FAIL mid_after got=%h v=%b exp=0000 v=0", out_onehot, out_valid); end
    in_valid = 1'b1; in_bin = 4'd7;
    @(negedge clk);
    n_cmp++; if (out_onehot !== 16'h0080 || out_valid !== 1'b1) begin n_mis++; $display("FAIL mid_resume got=%h v=%b exp=0080 v=1", out_onehot, out_valid); end
  endtask

  task automatic test_checker();
    logic exp_chk;
`ifdef BINARY_ONEHOT_ENCODER_CHECK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    n_cmp++; if (chk_err !== 1'b0) begin n_mis++; $display("FAIL chk_clean got=%b exp=0", chk_err); end
    force dut.out_onehot_q = 16'h0005;
    @(negedge clk);
    n_cmp++; if (chk_err !== exp_chk) begin n_mis++; $display("FAIL chk_set got=%b exp=%b", chk_err, exp_chk); end
    release dut.out_onehot_q;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (chk_err !== exp_chk) begin n_mis++; $display("FAIL chk_sticky got=%b exp=%b", chk_err, exp_chk); end
    n_cmp++; if (chk_err10 !== 1'b0) begin n_mis++; $display("FAIL chk_other got=%b exp=0", chk_err10); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (chk_err !== 1'b0) begin n_mis++; $display("FAIL chk_reset got=%b exp=0", chk_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bin = '0;
    test_reset();
    test_sweep();
    test_hold();
    test_out_of_range();
    test_midstream_reset();
    test_checker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
